// File: rtl/bsg_counter_clear_up_down_sat.sv
// Up/down counter with synchronous clear/load and saturating or modulo bounds.
// Define BSG_COUNTER_STICKY_ERR_EN to build the sticky overflow/underflow error flag.
module bsg_counter_clear_up_down_sat #(
   parameter int max_val_p  = 64,
   parameter int init_val_p = 0,
   parameter bit sat_p      = 1'b1,
   localparam int ptr_width_lp = $clog2(max_val_p+1)
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    clear_i,
   input  logic                    load_i,
   input  logic [ptr_width_lp-1:0] load_val_i,
   input  logic                    up_i,
   input  logic                    down_i,
   output logic [ptr_width_lp-1:0] count_o,
   output logic                    at_max_o,
   output logic                    at_zero_o,
   output logic                    ovf_o,
   output logic                    unf_o,
   output logic                    err_o
);

   localparam logic [ptr_width_lp-1:0] max_lp  = ptr_width_lp'(max_val_p);
   localparam logic [ptr_width_lp-1:0] init_lp = ptr_width_lp'(init_val_p);

   logic [ptr_width_lp-1:0] base, count_next;
   logic                    inc, dec, ovf_ev, unf_ev;

   always_comb begin
      base = count_o;
      if (clear_i)     base = init_lp;
      else if (load_i) base = load_val_i;
   end

   assign inc    = up_i & ~down_i;
   assign dec    = down_i & ~up_i;
   assign ovf_ev = inc & (base == max_lp);
   assign unf_ev = dec & (base == '0);

   // Compare against max_val_p explicitly so non-power-of-two ranges wrap correctly.
   always_comb begin
      count_next = base;
      if (ovf_ev)   count_next = sat_p ? max_lp : '0;
      else if (unf_ev) count_next = sat_p ? '0 : max_lp;
      else if (inc) count_next = base + 1'b1;
      else if (dec) count_next = base - 1'b1;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         count_o <= init_lp;
         ovf_o   <= 1'b0;
         unf_o   <= 1'b0;
      end else begin
         count_o <= count_next;
         ovf_o   <= ovf_ev;
         unf_o   <= unf_ev;
      end
   end

   assign at_max_o  = (count_o == max_lp);
   assign at_zero_o = (count_o == '0);

`ifdef BSG_COUNTER_STICKY_ERR_EN
   // A new event in the same cycle as clear_i wins, so the flag stays set.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)   err_o <= 1'b0;
      else if (clear_i) err_o <= ovf_ev | unf_ev;
      else              err_o <= err_o | ovf_ev | unf_ev;
   end
`else
   assign err_o = 1'b0;
`endif

endmodule
